// File: rtl/pipe_shift.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with
// valid/ready flow control that stalls every stage together.
module pipe_shift #(
  parameter int N    = 16,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic [1:0]      in_mode,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [TAGW-1:0] out_tag
);

  localparam int SW = $clog2(N);

  logic            v_q    [SW];
  logic [N-1:0]    d_q    [SW];
  logic [SW-1:0]   amt_q  [SW];
  logic [1:0]      mode_q [SW];
  logic [TAGW-1:0] tag_q  [SW];

  logic advance;

  // Arithmetic mode can use the current MSB as fill: right shifts never
  // disturb bit N-1 except by replicating it, so it stays the original sign.
  function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d,
                                               input logic [1:0]   mode,
                                               input logic         en,
                                               input int           sh);
    logic [N-1:0] r;
    r = d;
    if (en) begin
      case (mode)
        2'b00:   r = d >> sh;
        2'b01:   r = N'($signed(d) >>> sh);
        2'b10:   r = d << sh;
        default: r = (d >> sh) | (d << (N - sh));
      endcase
    end
    return r;
  endfunction

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SW; k++) begin
        v_q[k]    <= 1'b0;
        d_q[k]    <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (advance) begin
      v_q[0]    <= in_valid;
      d_q[0]    <= stage_shift(in_data, in_mode, in_amt[0], 1);
      amt_q[0]  <= in_amt;
      mode_q[0] <= in_mode;
      tag_q[0]  <= in_tag;
      for (int k = 1; k < SW; k++) begin
        v_q[k]    <= v_q[k-1];
        d_q[k]    <= stage_shift(d_q[k-1], mode_q[k-1], amt_q[k-1][k], 1 << k);
        amt_q[k]  <= amt_q[k-1];
        mode_q[k] <= mode_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
    end
  end

  assign out_valid = v_q[SW-1];
  assign out_data  = d_q[SW-1];
  assign out_tag   = tag_q[SW-1];

endmodule

// File: doc/pipe_shift.md
PIPE_SHIFT -- requirements
Module: pipe_shift

Interface
REQ-001 SHALL have parameter N, default 16, meaning data width; legal values are powers of two, 4..64.
REQ-002 SHALL have parameter TAGW, default 4, meaning the width of the sideband tag carried with each operation.
REQ-003 SHALL have localparam SW = clog2(N), meaning the shift-amount width and the pipeline depth.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream operation is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-008 SHALL have port in_data, input, N bits: the operand.
REQ-009 SHALL have port in_amt, input, SW bits: binary shift amount, 0..N-1.
REQ-010 SHALL have port in_mode, input, 2 bits: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
REQ-011 SHALL have port in_tag, input, TAGW bits: opaque tag returned unchanged with the result.
REQ-012 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have port out_data, output, N bits: the shifted result.
REQ-015 SHALL have port out_tag, output, TAGW bits: the tag of the result.

Function
REQ-016 SHALL implement SW registered stages; stage k shifts by 2^k when amount bit k is set, otherwise it passes the data through.
REQ-017 SHALL carry valid, the remaining amount bits, mode, tag and data in every stage register.
REQ-018 SHALL have a latency of exactly SW cycles from an accepted input (in_valid && in_ready) to out_valid, absent stalls.
REQ-019 SHALL sustain a throughput of one operation per cycle when out_ready is held high.
REQ-020 SHALL compute advance = !out_valid || out_ready, and SHALL drive in_ready = advance combinationally.
REQ-021 SHALL shift all stages together on advance; stage 0 loads valid = in_valid.
REQ-022 SHALL hold every stage register, including its data, when advance is 0.
REQ-023 SHALL propagate bubbles (valid = 0) through the pipeline; bubbles are never compressed.
REQ-024 SHALL fill vacated bit positions with 0 in modes 00 and 10.
REQ-025 SHALL fill vacated bit positions with bit N-1 of the original operand in mode 01.
REQ-026 SHALL move bits shifted out of bit 0 into bit N-1 in mode 11.
REQ-027 SHALL pass the operand unchanged for in_amt = 0 in every mode.
REQ-028 SHALL produce results in acceptance order, with no loss and no duplication of operations.
REQ-029 SHALL hold out_data and out_tag stable while out_valid && !out_ready.
REQ-030 SHALL ignore in_data, in_amt, in_mode and in_tag when in_valid = 0 or in_ready = 0.

Reset
REQ-031 SHALL, on any cycle with rst = 1, clear all stage valid bits, and set out_data = 0 and out_tag = 0 at the next edge.
REQ-032 SHALL give out_valid = 0 and in_ready = 1 in the first cycle after reset.
REQ-033 SHALL ignore any input presented while rst = 1.
REQ-034 SHALL, when rst is asserted mid-operation, discard all in-flight operations; none are ever emitted.

Verification (N = 16, SW = 4)
REQ-035 SHALL verify these scenarios with out_ready = 1 throughout:
- 0x8001, amt 1, mode 00 -> 0x4000 after 4 cycles.
- 0x8000, amt 15, mode 01 -> 0xFFFF.
- 0x0001, amt 15, mode 10 -> 0x8000.
- 0x0001, amt 1, mode 11 -> 0x8000.
REQ-036 SHALL verify 0xA5C3 with amt 0 in all four modes -> 0xA5C3 each time, with tags 0..3 returned in order.
REQ-037 SHALL verify back-to-back issue with backpressure:
- Stimulus: 6 back-to-back operations tagged 0..5; out_ready = 0 for 3 cycles once the first result appears.
- Response: in_ready = 0 and out_data/out_tag held while stalled.
- Response: all 6 results delivered in tag order, with none lost or duplicated.
REQ-038 SHALL verify bubbles: alternating in_valid = 1/0 gives out_valid alternating 1/0, 4 cycles later.
REQ-039 SHALL verify reset mid-flight:
- Stimulus: 3 operations accepted, then rst = 1 for 1 cycle.
- Response: out_valid = 0 and in_ready = 1 the next cycle, and no result is ever emitted for those 3.
